// File: rtl/adxl362_burst_reader.sv
// ADXL362 reader: powers up, writes measurement mode, then burst-reads 1-3 axes from 0x0E over SPI mode 0.
// Optional: define ADXL362_TEMP_EN to burst all 8 data bytes and publish temp_data.
module adxl362_burst_reader #(
  parameter int CLK_DIV     = 2,
  parameter int NUM_AXES    = 3,
  parameter int PWRUP_TICKS = 24000,
  parameter int IFG_TICKS   = 40000
) (
  input  logic                   iclk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   miso,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   cs,
  output logic [16*NUM_AXES-1:0] axis_data,
  output logic                   data_valid,
  output logic                   busy,
`ifdef ADXL362_TEMP_EN
  output logic [15:0]            temp_data,
`endif
  output logic [15:0]            frame_cnt
);

`ifdef ADXL362_TEMP_EN
  localparam int DATA_BYTES = 8;
`else
  localparam int DATA_BYTES = 2 * NUM_AXES;
`endif
  localparam int SH_W     = 8 * DATA_BYTES;
  localparam int WAIT_MAX = (PWRUP_TICKS > IFG_TICKS) ? PWRUP_TICKS : IFG_TICKS;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int DIV_W    = $clog2(CLK_DIV);

  localparam logic [3:0]        WRITE_LAST = 4'd2;
  localparam logic [3:0]        READ_LAST  = 4'(1 + DATA_BYTES);
  localparam logic [WAIT_W-1:0] PWRUP_END  = WAIT_W'(PWRUP_TICKS - 1);
  localparam logic [WAIT_W-1:0] IFG_END    = WAIT_W'(IFG_TICKS - 1);
  localparam logic [DIV_W-1:0]  DIV_END    = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [2:0]        bit_idx;
  logic [3:0]        byte_idx;
  logic              tail;
  logic [6:0]        rx_sr;
  logic [SH_W-1:0]   shadow;
  logic [7:0]        tx_byte;
  logic [3:0]        last_byte;

  always_comb begin
    tx_byte = 8'h00;
    if (state == ST_WRITE) begin
      case (byte_idx)
        4'd0:    tx_byte = 8'h0A;
        4'd1:    tx_byte = 8'h2D;
        default: tx_byte = 8'h02;
      endcase
    end else if (state == ST_READ) begin
      case (byte_idx)
        4'd0:    tx_byte = 8'h0B;
        4'd1:    tx_byte = 8'h0E;
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign last_byte = (state == ST_WRITE) ? WRITE_LAST : READ_LAST;
  assign mosi      = (!cs && !tail) ? tx_byte[~bit_idx] : 1'b0;
  assign busy      = ~cs;

  // Each half-period of CLK_DIV ticks either raises sclk (sample), lowers it (advance bit),
  // or, after the final falling edge, closes the transaction by raising cs.
  always_ff @(posedge iclk) begin
    if (rst) begin
      state      <= ST_PWRUP;
      wait_cnt   <= '0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      tail       <= 1'b0;
      rx_sr      <= '0;
      shadow     <= '0;
      cs         <= 1'b1;
      sclk       <= 1'b0;
      axis_data  <= '0;
      data_valid <= 1'b0;
      frame_cnt  <= '0;
`ifdef ADXL362_TEMP_EN
      temp_data  <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_PWRUP: begin
          if (wait_cnt == PWRUP_END) begin
            state <= ST_WRITE;
            cs    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WRITE, ST_READ: begin
          if (div_cnt != DIV_END) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (tail) begin
              cs       <= 1'b1;
              tail     <= 1'b0;
              byte_idx <= '0;
              wait_cnt <= '0;
              state    <= (state == ST_WRITE) ? ST_GAP : ST_DONE;
            end else if (!sclk) begin
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[5:0], miso};
              if (state == ST_READ && bit_idx == 3'd7 && byte_idx >= 4'd2)
                shadow <= {rx_sr, miso, shadow[SH_W-1:8]};
            end else begin
              sclk    <= 1'b0;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) begin
                if (byte_idx == last_byte)
                  tail <= 1'b1;
                else
                  byte_idx <= byte_idx + 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          // Counter saturates at its end value so a later enable starts the frame at once.
          if (wait_cnt != IFG_END) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else if (enable) begin
            state <= ST_READ;
            cs    <= 1'b0;
          end
        end
        ST_DONE: begin
          axis_data  <= shadow[16*NUM_AXES-1:0];
`ifdef ADXL362_TEMP_EN
          temp_data  <= shadow[63:48];
`endif
          data_valid <= 1'b1;
          frame_cnt  <= frame_cnt + 1'b1;
          wait_cnt   <= '0;
          state      <= ST_GAP;
        end
        default: begin
          state <= ST_PWRUP;
          cs    <= 1'b1;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adxl362_burst_reader.sv
// Self-checking bench for adxl362_burst_reader with a behavioural ADXL362 SPI slave.
`timescale 1ns/1ps
module tb_adxl362_burst_reader;
  localparam int CLK_DIV     = 2;
  localparam int NUM_AXES    = 3;
  localparam int PWRUP_TICKS = 100;
  localparam int IFG_TICKS   = 200;
  localparam int PERIOD      = 10;
  localparam int BUDGET      = 3000;
`ifdef ADXL362_TEMP_EN
  localparam int DATA_BYTES = 8;
`else
  localparam int DATA_BYTES = 2 * NUM_AXES;
`endif
  localparam int READ_RISES = 8 * (2 + DATA_BYTES);

  logic iclk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic miso;
  logic sclk, mosi, cs, data_valid, busy;
  logic [16*NUM_AXES-1:0] axis_data;
  logic [15:0] frame_cnt;
`ifdef ADXL362_TEMP_EN
  logic [15:0] temp_data;
`endif

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  always #(PERIOD/2) iclk = ~iclk;

  adxl362_burst_reader #(
    .CLK_DIV(CLK_DIV), .NUM_AXES(NUM_AXES),
    .PWRUP_TICKS(PWRUP_TICKS), .IFG_TICKS(IFG_TICKS)
  ) dut (
    .iclk(iclk), .rst(rst), .enable(enable), .miso(miso),
    .sclk(sclk), .mosi(mosi), .cs(cs), .axis_data(axis_data),
    .data_valid(data_valid), .busy(busy),
`ifdef ADXL362_TEMP_EN
    .temp_data(temp_data),
`endif
    .frame_cnt(frame_cnt)
  );

  // Behavioural ADXL362: registers 0x0E.. return slave_bytes after the 2-byte header.
  logic [7:0] slave_bytes [8];
  int fall_cnt = 0, rise_cnt = 0, last_rises = 0, cs_fall_count = 0;
  int lead_cyc = 0, trail_cyc = 0, last_gap = 0;
  time t_cs_rise = 0, t_cs_fall = 0, t_last_fall = 0;
  logic [7:0] mosi_sr = 8'h00;
  logic [7:0] cur_log[$];
  logic [7:0] last_log[$];

  always @(negedge cs) begin
    fall_cnt = 0;
    rise_cnt = 0;
    cur_log.delete();
    last_gap = int'(($time - t_cs_rise) / PERIOD);
    t_cs_fall = $time;
    cs_fall_count++;
  end

  always @(posedge cs) begin
    last_rises = rise_cnt;
    last_log = cur_log;
    trail_cyc = int'(($time - t_last_fall) / PERIOD);
    t_cs_rise = $time;
  end

  always @(negedge sclk) begin
    if (cs === 1'b0) begin
      fall_cnt++;
      t_last_fall = $time;
    end
  end

  always @(posedge sclk) begin
    if (cs === 1'b0) begin
      mosi_sr = {mosi_sr[6:0], mosi};
      rise_cnt++;
      if (rise_cnt == 1) lead_cyc = int'(($time - t_cs_fall) / PERIOD);
      if (rise_cnt % 8 == 0) cur_log.push_back(mosi_sr);
    end
  end

  always @* begin
    automatic int k = fall_cnt / 8;
    if (cs !== 1'b0 || k < 2 || k >= 2 + DATA_BYTES) miso = 1'b0;
    else miso = slave_bytes[k-2][7 - (fall_cnt % 8)];
  end

  typedef struct {
    logic [15:0] x, y, z, t;
    logic [47:0] exp_axis;
    logic [15:0] exp_temp;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [47:0] modelAxis(input vec_t v);
    logic [15:0] ax [3];
    logic [47:0] r;
    ax[0] = v.x; ax[1] = v.y; ax[2] = v.z;
    r = '0;
    for (int a = 0; a < NUM_AXES; a++) r = r | (48'(ax[a]) << (16 * a));
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    slave_bytes[0] = v.x[7:0]; slave_bytes[1] = v.x[15:8];
    slave_bytes[2] = v.y[7:0]; slave_bytes[3] = v.y[15:8];
    slave_bytes[4] = v.z[7:0]; slave_bytes[5] = v.z[15:8];
    slave_bytes[6] = v.t[7:0]; slave_bytes[7] = v.t[15:8];
  endtask

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkAtLeast(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required>=%0d", name, act, min);
    end
  endtask

  task automatic packLog(output logic [79:0] v, output int n);
    n = last_log.size();
    v = '0;
    for (int j = 0; j < n && j < 10; j++) v = {v[71:0], last_log[j]};
  endtask

  task automatic waitStrobe(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge iclk);
      if (data_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitCs(input logic level, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int c = 0; c < BUDGET; c++) begin
      if (cs === level) begin ok = 1'b1; break; end
      @(negedge iclk);
      cyc++;
    end
  endtask

  task automatic checkWriteFrame(input string tag);
    logic [79:0] lv;
    int n;
    packLog(lv, n);
    checkOutput({tag, "_write_rises"}, 80'(last_rises), 80'(24));
    checkOutput({tag, "_write_nbytes"}, 80'(n), 80'(3));
    checkOutput({tag, "_write_bytes"}, lv, 80'h0A2D02);
  endtask

  task automatic frameCheck(input string tag, input vec_t v);
    bit ok;
    logic [79:0] lv, ev;
    int n;
    waitStrobe(ok);
    checkOutput({tag, "_strobe_seen"}, 80'(ok), 80'(1));
    if (ok) begin
      exp_frames++;
      checkOutput({tag, "_axis"}, 80'(axis_data), 80'(v.exp_axis));
      checkOutput({tag, "_frame_cnt"}, 80'(frame_cnt), 80'(exp_frames[15:0]));
      checkOutput({tag, "_busy_idle"}, 80'(busy), 80'(0));
`ifdef ADXL362_TEMP_EN
      checkOutput({tag, "_temp"}, 80'(temp_data), 80'(v.exp_temp));
`endif
      checkOutput({tag, "_read_rises"}, 80'(last_rises), 80'(READ_RISES));
      packLog(lv, n);
      ev = 80'h0B0E;
      for (int j = 0; j < DATA_BYTES; j++) ev = {ev[71:0], 8'h00};
      checkOutput({tag, "_read_nbytes"}, 80'(n), 80'(2 + DATA_BYTES));
      checkOutput({tag, "_read_bytes"}, lv, ev);
      checkAtLeast({tag, "_gap"}, last_gap, IFG_TICKS);
      checkAtLeast({tag, "_lead"}, lead_cyc, CLK_DIV);
      checkAtLeast({tag, "_trail"}, trail_cyc, CLK_DIV);
      @(negedge iclk);
      checkOutput({tag, "_strobe_one_cycle"}, 80'(data_valid), 80'(0));
      checkOutput({tag, "_axis_hold"}, 80'(axis_data), 80'(v.exp_axis));
    end
  endtask

  initial begin
    bit ok;
    int cyc, f0, strobes;
    vec_t v;

    vecs[0] = '{x:16'h0123, y:16'hFF80, z:16'h07FF, t:16'h0807, exp_axis:48'h07FF_FF80_0123, exp_temp:16'h0807};
    vecs[1] = '{x:16'h0000, y:16'h0000, z:16'h0000, t:16'h0000, exp_axis:48'h0, exp_temp:16'h0000};
    vecs[2] = '{x:16'hFFFF, y:16'hFFFF, z:16'hFFFF, t:16'hFFFF, exp_axis:48'hFFFF_FFFF_FFFF, exp_temp:16'hFFFF};
    vecs[3] = '{x:16'hA55A, y:16'h5AA5, z:16'h8001, t:16'h1234, exp_axis:48'h8001_5AA5_A55A, exp_temp:16'h1234};
    for (int i = 4; i < 8; i++) begin
      vecs[i].x = 16'($urandom); vecs[i].y = 16'($urandom);
      vecs[i].z = 16'($urandom); vecs[i].t = 16'($urandom);
      vecs[i].exp_axis = modelAxis(vecs[i]);
      vecs[i].exp_temp = vecs[i].t;
    end

    applyStimulus(vecs[0]);
    rst = 1'b1;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    checkOutput("reset_cs", 80'(cs), 80'(1));
    checkOutput("reset_sclk", 80'(sclk), 80'(0));
    checkOutput("reset_mosi", 80'(mosi), 80'(0));
    checkOutput("reset_axis", 80'(axis_data), 80'(0));
    checkOutput("reset_valid", 80'(data_valid), 80'(0));
    checkOutput("reset_busy", 80'(busy), 80'(0));
    checkOutput("reset_frame_cnt", 80'(frame_cnt), 80'(0));

    rst = 1'b0;
    waitCs(1'b0, ok, cyc);
    checkOutput("pwrup_cs_fall_seen", 80'(ok), 80'(1));
    checkOutput("pwrup_wait", 80'(cyc), 80'(PWRUP_TICKS));
    @(negedge iclk);
    checkOutput("write_busy", 80'(busy), 80'(1));
    waitCs(1'b1, ok, cyc);
    checkOutput("write_end_seen", 80'(ok), 80'(1));
    checkWriteFrame("init");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      frameCheck($sformatf("vec%0d", i), vecs[i]);
    end

    // Enable dropped in the middle of a read: frame must still complete and strobe.
    v = '{x:16'h1357, y:16'h2468, z:16'hBEEF, t:16'h0A0B, exp_axis:48'hBEEF_2468_1357, exp_temp:16'h0A0B};
    applyStimulus(v);
    waitCs(1'b0, ok, cyc);
    checkOutput("en_read_start_seen", 80'(ok), 80'(1));
    repeat (60) @(negedge iclk);
    checkOutput("en_mid_busy", 80'(busy), 80'(1));
    enable = 1'b0;
    frameCheck("en_drop", v);
    f0 = cs_fall_count;
    repeat (3 * IFG_TICKS) @(negedge iclk);
    checkOutput("en_no_cs_low", 80'(cs_fall_count - f0), 80'(0));
    checkOutput("en_cs_high", 80'(cs), 80'(1));
    v = vecs[3];
    applyStimulus(v);
    enable = 1'b1;
    waitCs(1'b0, ok, cyc);
    checkOutput("en_restart_seen", 80'(ok), 80'(1));
    checkOutput("en_restart_prompt", 80'(cyc <= 2), 80'(1));
    frameCheck("en_resume", v);

    // Reset pulsed during the third data byte of a read.
    v = vecs[2];
    applyStimulus(v);
    waitCs(1'b0, ok, cyc);
    checkOutput("rst_read_start_seen", 80'(ok), 80'(1));
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge iclk);
      if (rise_cnt >= 8 * 4 + 3) begin ok = 1'b1; break; end
    end
    checkOutput("rst_third_byte_reached", 80'(ok), 80'(1));
    rst = 1'b1;
    @(negedge iclk);
    checkOutput("rst_mid_cs", 80'(cs), 80'(1));
    checkOutput("rst_mid_sclk", 80'(sclk), 80'(0));
    checkOutput("rst_mid_axis", 80'(axis_data), 80'(0));
    checkOutput("rst_mid_frame_cnt", 80'(frame_cnt), 80'(0));
    checkOutput("rst_mid_valid", 80'(data_valid), 80'(0));
    checkOutput("rst_mid_busy", 80'(busy), 80'(0));
    rst = 1'b0;
    exp_frames = 0;
    strobes = 0;
    cyc = 0;
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (cs === 1'b0) begin ok = 1'b1; break; end
      @(negedge iclk);
      cyc++;
      if (data_valid === 1'b1) strobes++;
    end
    checkOutput("rst_repwrup_seen", 80'(ok), 80'(1));
    checkOutput("rst_repwrup_wait", 80'(cyc), 80'(PWRUP_TICKS));
    checkOutput("rst_no_strobe", 80'(strobes), 80'(0));
    waitCs(1'b1, ok, cyc);
    checkOutput("rst_write_end_seen", 80'(ok), 80'(1));
    checkWriteFrame("rst");
    frameCheck("post_rst", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
